// File: rtl/divisibility_check_arbiter_pkg.sv
// rtl/divisibility_check_arbiter_pkg.sv - shared states and width helpers
// for the divisibility check arbiter.
package divisibility_check_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic int idw_of(input int nreq);
      return (clog2(nreq) < 1) ? 1 : clog2(nreq);
   endfunction

   function automatic int rem_w_of(input int divisor);
      return clog2(divisor);
   endfunction

   function automatic int cnt_w_of(input int width);
      return (clog2(width) < 1) ? 1 : clog2(width);
   endfunction

endpackage

// File: rtl/divisibility_check_arbiter_serial_mod_engine.sv
// rtl/divisibility_check_arbiter_serial_mod_engine.sv - MSB-first serial
// remainder engine, one operand bit per enabled cycle.
module serial_mod_engine
   import divisibility_check_arbiter_pkg::*;
#(
   parameter int DIVISOR = 4,
   localparam int REM_W = rem_w_of(DIVISOR)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             bit_in,
   output logic [REM_W-1:0] rem
);

   localparam logic [REM_W:0] DIV_V = (REM_W+1)'(DIVISOR);

   logic [REM_W:0] sum;
   logic [REM_W:0] reduced;

   // 2*rem+bit is below 2*DIVISOR, so a single conditional subtract reduces it.
   always_comb begin
      sum     = {rem, bit_in};
      reduced = (sum >= DIV_V) ? (sum - DIV_V) : sum;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem <= '0;
      end else if (clr) begin
         rem <= '0;
      end else if (en) begin
         rem <= reduced[REM_W-1:0];
      end
   end

endmodule

// File: rtl/divisibility_check_arbiter.sv
// rtl/divisibility_check_arbiter.sv - round-robin scheduler sharing one
// serial remainder engine among NREQ requesters.
module divisibility_check_arbiter
   import divisibility_check_arbiter_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 8,
   parameter int DIVISOR = 4,
   localparam int IDW   = idw_of(NREQ),
   localparam int REM_W = rem_w_of(DIVISOR),
   localparam int CNT_W = cnt_w_of(WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  res_valid,
   output logic [IDW-1:0]        res_id,
   output logic [REM_W-1:0]      res_remainder,
   output logic                  res_divisible,
   output logic                  busy
);

   state_t            state;
   state_t            state_next;
   logic [IDW-1:0]    rr_ptr;
   logic [IDW-1:0]    cur_id;
   logic [IDW-1:0]    res_id_q;
   logic [REM_W-1:0]  res_rem_q;
   logic              res_div_q;
   logic [CNT_W-1:0]  cnt;
   logic [WIDTH-1:0]  shift_reg;
   logic [REM_W-1:0]  eng_rem;
   logic              gnt_found;
   logic [IDW-1:0]    gnt;
   int                idx;

   always_comb begin
      state_next = state;
      gnt_found  = 1'b0;
      gnt        = '0;
      idx        = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt       = IDW'(idx);
         end
      end
      case (state)
         IDLE:    if (gnt_found) state_next = SHIFT;
         SHIFT:   if (cnt == CNT_W'(WIDTH-1)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cur_id    <= '0;
         res_id_q  <= '0;
         res_rem_q <= '0;
         res_div_q <= 1'b0;
         cnt       <= '0;
         shift_reg <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: if (gnt_found) begin
               shift_reg <= req_data[int'(gnt)*WIDTH +: WIDTH];
               cur_id    <= gnt;
               cnt       <= '0;
               rr_ptr    <= (int'(gnt) == NREQ-1) ? '0 : gnt + 1'b1;
            end
            SHIFT: begin
               shift_reg <= shift_reg << 1;
               cnt       <= cnt + 1'b1;
            end
            DONE: begin
               res_id_q  <= cur_id;
               res_rem_q <= eng_rem;
               res_div_q <= (eng_rem == '0);
            end
            default: ;
         endcase
      end
   end

   serial_mod_engine #(.DIVISOR(DIVISOR)) u_engine (
      .clk    (clk),
      .reset  (reset),
      .clr    (state == IDLE && gnt_found),
      .en     (state == SHIFT),
      .bit_in (shift_reg[WIDTH-1]),
      .rem    (eng_rem)
   );

   // The engine holds the final remainder during DONE; registers keep it afterwards.
   assign req_ready     = (state == IDLE && gnt_found && !reset) ? (NREQ'(1) << gnt) : '0;
   assign res_valid     = (state == DONE) && !reset;
   assign busy          = (state != IDLE) && !reset;
   assign res_id        = (state == DONE) ? cur_id : res_id_q;
   assign res_remainder = (state == DONE) ? eng_rem : res_rem_q;
   assign res_divisible = (state == DONE) ? (eng_rem == '0) : res_div_q;

endmodule

// File: tb/tb_divisibility_check_arbiter.sv
// tb/tb_divisibility_check_arbiter.sv - scoreboard bench for the
// divisibility check arbiter (DIVISOR=4 main instance, DIVISOR=3 second).
module tb_divisibility_check_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int DIV   = 4;

   typedef struct {
      int id;
      int rem;
      bit div;
      int due;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ*WIDTH-1:0] req_data = '0;
   logic [NREQ-1:0]       req_ready;
   logic                  res_valid;
   logic [1:0]            res_id;
   logic [1:0]            res_remainder;
   logic                  res_divisible;
   logic                  busy;

   logic [NREQ-1:0]       d3_valid = '0;
   logic [NREQ*WIDTH-1:0] d3_data = '0;
   logic [NREQ-1:0]       d3_ready;
   logic                  d3_res_valid;
   logic [1:0]            d3_res_id;
   logic [1:0]            d3_res_remainder;
   logic                  d3_res_divisible;
   logic                  d3_busy;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   exp_t sb[$];
   int   glog[$];
   int   gcyc[$];

   int              m_rr = 0;
   int              m_busy = 0;
   logic [NREQ-1:0] m_ready;
   bit              m_found;
   int              m_g;
   bit              m_expv;
   exp_t            m_e;

   always #5 clk = ~clk;

   divisibility_check_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DIVISOR(DIV)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .res_valid(res_valid), .res_id(res_id),
      .res_remainder(res_remainder), .res_divisible(res_divisible), .busy(busy)
   );

   divisibility_check_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DIVISOR(3)) dut3 (
      .clk(clk), .reset(reset), .req_valid(d3_valid), .req_data(d3_data),
      .req_ready(d3_ready), .res_valid(d3_res_valid), .res_id(d3_res_id),
      .res_remainder(d3_res_remainder), .res_divisible(d3_res_divisible), .busy(d3_busy)
   );

   // Cycle model of the main instance: grant, busy window and result timing.
   always @(negedge clk) begin
      cyc++;
      for (int k = 0; k < NREQ; k++)
         if (req_ready[k]) begin
            glog.push_back(k);
            gcyc.push_back(cyc);
         end
      if (reset) begin
         m_rr = 0;
         m_busy = 0;
         sb.delete();
         vectors++;
         if (req_ready !== '0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs ready=%b valid=%b busy=%b required 0", req_ready, res_valid, busy);
         end
      end else begin
         m_ready = '0;
         m_found = 1'b0;
         m_g = 0;
         if (m_busy == 0)
            for (int k = 0; k < NREQ; k++)
               if (!m_found && req_valid[(m_rr + k) % NREQ]) begin
                  m_found = 1'b1;
                  m_g = (m_rr + k) % NREQ;
               end
         if (m_found) m_ready[m_g] = 1'b1;
         vectors++;
         if (req_ready !== m_ready) begin
            miscompares++;
            $display("FAIL grant cyc=%0d ready=%b required %b", cyc, req_ready, m_ready);
         end
         vectors++;
         if (busy !== (m_busy > 0)) begin
            miscompares++;
            $display("FAIL busy cyc=%0d got %b required %b", cyc, busy, (m_busy > 0));
         end
         m_expv = (sb.size() > 0) && (sb[0].due == cyc);
         vectors++;
         if (res_valid !== m_expv) begin
            miscompares++;
            $display("FAIL res_valid cyc=%0d got %b required %b", cyc, res_valid, m_expv);
         end
         if (m_expv) begin
            m_e = sb.pop_front();
            vectors++;
            if (int'(res_id) != m_e.id || int'(res_remainder) != m_e.rem || res_divisible !== m_e.div) begin
               miscompares++;
               $display("FAIL result cyc=%0d id/rem/div=%0d/%0d/%b required %0d/%0d/%b",
                        cyc, res_id, res_remainder, res_divisible, m_e.id, m_e.rem, m_e.div);
            end
         end
         if (m_found) begin
            m_e.id  = m_g;
            m_e.rem = int'(req_data[m_g*WIDTH +: WIDTH]) % DIV;
            m_e.div = (m_e.rem == 0);
            m_e.due = cyc + WIDTH + 1;
            sb.push_back(m_e);
            m_rr = (m_g + 1) % NREQ;
            m_busy = WIDTH + 1;
         end else if (m_busy > 0) begin
            m_busy--;
         end
      end
   end

   task automatic wait_grant(input int i);
      bit got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
         @(negedge clk);
         if (req_ready[i]) got = 1'b1;
      end
      @(posedge clk);
      #1 req_valid[i] = 1'b0;
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL grant_timeout req=%0d got no ready required ready", i);
      end
   endtask

   task automatic issue(input int i, input logic [WIDTH-1:0] d);
      @(posedge clk);
      #1;
      req_data[i*WIDTH +: WIDTH] = d;
      req_valid[i] = 1'b1;
      wait_grant(i);
   endtask

   task automatic test_reset;
      @(negedge clk);
      vectors++;
      if (res_id !== 2'd0 || res_remainder !== 2'd0 || res_divisible !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state id/rem/div/busy=%0d/%0d/%b/%b required 0/0/0/0",
                  res_id, res_remainder, res_divisible, busy);
      end
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_single;
      issue(0, 8'h0C);
      repeat (12) @(posedge clk);
      #1;
      vectors++;
      if (res_id !== 2'd0 || res_remainder !== 2'd0 || res_divisible !== 1'b1) begin
         miscompares++;
         $display("FAIL single_0c id/rem/div=%0d/%0d/%b required 0/0/1", res_id, res_remainder, res_divisible);
      end
      issue(0, 8'h0D);
      repeat (12) @(posedge clk);
      #1;
      vectors++;
      if (res_remainder !== 2'd1 || res_divisible !== 1'b0) begin
         miscompares++;
         $display("FAIL single_0d rem/div=%0d/%b required 1/0", res_remainder, res_divisible);
      end
   endtask

   task automatic test_all_four;
      @(posedge clk);
      #1 reset = 1'b1;
      req_data = {8'hA3, 8'h10, 8'h07, 8'h0E};
      req_valid = '1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      glog.delete();
      gcyc.delete();
      repeat (45) @(posedge clk);
      #1 req_valid = '0;
      repeat (15) @(posedge clk);
      vectors++;
      if (glog.size() != 5) begin
         miscompares++;
         $display("FAIL rr_count got %0d grants required 5", glog.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (glog[i] != i % NREQ) begin
               miscompares++;
               $display("FAIL rr_order idx=%0d got %0d required %0d", i, glog[i], i % NREQ);
            end
            if (i > 0) begin
               vectors++;
               if (gcyc[i] - gcyc[i-1] != WIDTH + 2) begin
                  miscompares++;
                  $display("FAIL rr_spacing idx=%0d got %0d required %0d", i, gcyc[i] - gcyc[i-1], WIDTH + 2);
               end
            end
         end
      end
   endtask

   task automatic test_skip;
      issue(1, 8'h21);
      repeat (12) @(posedge clk);
      glog.delete();
      #1;
      req_data[1*WIDTH +: WIDTH] = 8'h05;
      req_data[3*WIDTH +: WIDTH] = 8'h42;
      req_valid[1] = 1'b1;
      req_valid[3] = 1'b1;
      wait_grant(3);
      wait_grant(1);
      repeat (12) @(posedge clk);
      vectors++;
      if (glog.size() != 2 || glog[0] != 3 || glog[1] != 1) begin
         miscompares++;
         $display("FAIL skip_order got %p required '{3, 1}", glog);
      end
      glog.delete();
      #1;
      req_valid[1] = 1'b1;
      req_valid[3] = 1'b1;
      wait_grant(3);
      req_valid[1] = 1'b0;
      repeat (25) @(posedge clk);
      vectors++;
      if (glog.size() != 1 || glog[0] != 3) begin
         miscompares++;
         $display("FAIL drop_before_grant got %p required '{3}", glog);
      end
   endtask

   task automatic test_data_change;
      issue(2, 8'h37);
      req_data[2*WIDTH +: WIDTH] = 8'hFC;
      repeat (12) @(posedge clk);
      #1;
      vectors++;
      if (res_id !== 2'd2 || res_remainder !== 2'd3 || res_divisible !== 1'b0) begin
         miscompares++;
         $display("FAIL data_change id/rem/div=%0d/%0d/%b required 2/3/0", res_id, res_remainder, res_divisible);
      end
   endtask

   task automatic test_reset_mid;
      issue(0, 8'h0E);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      vectors++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || res_id !== 2'd0 || res_remainder !== 2'd0 || res_divisible !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid busy/valid/id/rem/div=%b/%b/%0d/%0d/%b required 0/0/0/0/0",
                  busy, res_valid, res_id, res_remainder, res_divisible);
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      glog.delete();
      req_data[0*WIDTH +: WIDTH] = 8'h09;
      req_data[2*WIDTH +: WIDTH] = 8'h0B;
      req_valid[0] = 1'b1;
      req_valid[2] = 1'b1;
      wait_grant(0);
      wait_grant(2);
      repeat (12) @(posedge clk);
      vectors++;
      if (glog.size() < 1 || glog[0] != 0) begin
         miscompares++;
         $display("FAIL post_reset_first got %p required first 0", glog);
      end
   endtask

   task automatic test_div3;
      logic [7:0] vals [3];
      int         er;
      bit         got;
      vals = '{8'hFF, 8'h64, 8'h00};
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         d3_data[7:0] = vals[i];
         d3_valid = 4'b0001;
         er = int'(vals[i]) % 3;
         got = 1'b0;
         for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (d3_ready[0]) got = 1'b1;
         end
         @(posedge clk);
         #1 d3_valid = '0;
         got = 1'b0;
         for (int t = 0; t < 30 && !got; t++) begin
            @(negedge clk);
            if (d3_res_valid) got = 1'b1;
         end
         vectors++;
         if (!got) begin
            miscompares++;
            $display("FAIL div3_timeout val=%h got no res_valid required res_valid", vals[i]);
         end else if (int'(d3_res_remainder) != er || d3_res_divisible !== (er == 0) || d3_res_id !== 2'd0) begin
            miscompares++;
            $display("FAIL div3 val=%h id/rem/div=%0d/%0d/%b required 0/%0d/%b",
                     vals[i], d3_res_id, d3_res_remainder, d3_res_divisible, er, (er == 0));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_skip();
      test_data_change();
      test_reset_mid();
      test_div3();
      repeat (2) @(posedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
